// File: rtl/altsource_probe_mc_pkg.sv
// Shared types for the multi-channel source/probe node: DR opcodes and scan FSM states.
package altsource_probe_mc_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_BYPASS       = 2'd0,
        OP_READ_PROBE   = 2'd1,
        OP_WRITE_SOURCE = 2'd2,
        OP_READ_SOURCE  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE
    } state_e;

    // A channel index that does not exist turns any opcode into BYPASS.
    function automatic op_e decode_op(input logic [OP_W-1:0] raw, input logic in_range);
        return in_range ? op_e'(raw) : OP_BYPASS;
    endfunction

endpackage

// File: rtl/altsource_probe_mc_sync.sv
// Parametrised-width bank of 2-flop synchronizers; both stages clear to 0 on reset.
module altsource_probe_mc_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_sync take the old r_meta, forming two real stages.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/altsource_probe_mc.sv
// Multi-channel in-system source/probe node behind one serial scan DR.
// Build option: define PROBE_SYNC_EN to synchronize probe inputs before capture.
module altsource_probe_mc #(
    parameter int                      NUM_CH       = 4,
    parameter int                      PROBE_WIDTH  = 32,
    parameter int                      SOURCE_WIDTH = 32,
    parameter logic [SOURCE_WIDTH-1:0] SOURCE_INIT  = '0,
    parameter int                      IR_WIDTH     = 4
) (
    input  logic                           source_clk,
    input  logic                           clr,
    input  logic                           ena,
    input  logic                           tck_ena,
    input  logic [IR_WIDTH-1:0]            ir_in,
    input  logic                           jtag_state_cdr,
    input  logic                           jtag_state_sdr,
    input  logic                           jtag_state_udr,
    input  logic                           tdi,
    output logic                           tdo,
    output logic [IR_WIDTH-1:0]            ir_out,
    input  logic [NUM_CH*PROBE_WIDTH-1:0]  probe,
    input  logic                           source_ena,
    output logic [NUM_CH*SOURCE_WIDTH-1:0] source,
    output logic [NUM_CH-1:0]              source_update
);

    import altsource_probe_mc_pkg::*;

    localparam int DR_W  = (PROBE_WIDTH > SOURCE_WIDTH) ? PROBE_WIDTH : SOURCE_WIDTH;
    localparam int IDX_W = IR_WIDTH - OP_W;

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic [DR_W-1:0]                r_sr;
    logic [IR_WIDTH-1:0]            r_ir;
    logic                           r_pend;
    logic [SOURCE_WIDTH-1:0]        r_pend_data;
    logic [IDX_W-1:0]               r_pend_ch;
    logic [NUM_CH*SOURCE_WIDTH-1:0] r_src;
    logic [NUM_CH-1:0]              r_upd;

    logic                           w_act;
    logic                           w_cdr;
    logic                           w_sdr;
    logic                           w_udr;
    logic                           w_do_cap;
    logic                           w_do_shift;
    logic                           w_do_upd;
    logic                           w_arm;
    logic                           w_commit;
    logic [IDX_W-1:0]               w_in_idx;
    logic [IDX_W-1:0]               w_lat_idx;
    op_e                            w_in_op;
    op_e                            w_lat_op;
    logic [DR_W-1:0]                w_cap_data;
    logic [NUM_CH*PROBE_WIDTH-1:0]  w_probe;

`ifdef PROBE_SYNC_EN
    altsource_probe_mc_sync #(
        .WIDTH (NUM_CH*PROBE_WIDTH)
    ) u_probe_sync (
        .i_clk (source_clk),
        .i_rst (clr),
        .i_d   (probe),
        .o_q   (w_probe)
    );
`else
    assign w_probe = probe;
`endif

    // Strobes are qualified by node select and TCK step, then prioritised cdr > sdr > udr.
    assign w_act = ena & tck_ena;
    assign w_cdr = w_act & jtag_state_cdr;
    assign w_sdr = w_act & jtag_state_sdr & ~jtag_state_cdr;
    assign w_udr = w_act & jtag_state_udr & ~jtag_state_sdr & ~jtag_state_cdr;

    // Capture decodes the live IR; shift and update use the IR latched at capture.
    assign w_in_idx  = ir_in[IR_WIDTH-1:OP_W];
    assign w_lat_idx = r_ir[IR_WIDTH-1:OP_W];
    assign w_in_op   = decode_op(ir_in[OP_W-1:0], int'(w_in_idx) < NUM_CH);
    assign w_lat_op  = decode_op(r_ir[OP_W-1:0], int'(w_lat_idx) < NUM_CH);

    always_ff @(posedge source_clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_do_cap    = 1'b0;
        w_do_shift  = 1'b0;
        w_do_upd    = 1'b0;
        if (w_cdr) begin
            w_state_nxt = ST_CAPTURE;
            w_do_cap    = 1'b1;
        end else if (w_sdr && (r_state == ST_CAPTURE || r_state == ST_SHIFT)) begin
            w_state_nxt = ST_SHIFT;
            w_do_shift  = 1'b1;
        end else if (w_udr && (r_state == ST_CAPTURE || r_state == ST_SHIFT)) begin
            w_state_nxt = ST_UPDATE;
            w_do_upd    = 1'b1;
        end else if (ena && r_state == ST_UPDATE) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_cap_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(w_in_idx) == c) begin
                case (w_in_op)
                    OP_READ_PROBE:  w_cap_data = DR_W'(w_probe[c*PROBE_WIDTH +: PROBE_WIDTH]);
                    OP_READ_SOURCE: w_cap_data = DR_W'(r_src[c*SOURCE_WIDTH +: SOURCE_WIDTH]);
                    default:        w_cap_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge source_clk or posedge clr) begin
        if (clr) begin
            r_sr <= '0;
            r_ir <= '0;
        end else if (w_do_cap) begin
            r_ir <= ir_in;
            r_sr <= w_cap_data;
        end else if (w_do_shift) begin
            if (w_lat_op == OP_BYPASS) begin
                r_sr[0] <= tdi;
            end else begin
                r_sr <= {tdi, r_sr[DR_W-1:1]};
            end
        end
    end

    // A new WRITE_SOURCE update takes priority over clearing, so it re-arms in a commit cycle.
    assign w_arm    = w_do_upd & (w_lat_op == OP_WRITE_SOURCE);
    assign w_commit = r_pend & source_ena;

    always_ff @(posedge source_clk or posedge clr) begin
        if (clr) begin
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_ch   <= '0;
        end else if (w_arm) begin
            r_pend      <= 1'b1;
            r_pend_data <= r_sr[SOURCE_WIDTH-1:0];
            r_pend_ch   <= w_lat_idx;
        end else if (w_commit) begin
            r_pend      <= 1'b0;
        end
    end

    always_ff @(posedge source_clk or posedge clr) begin
        if (clr) begin
            // NOTE: source is a flop bank, not a RAM, so every channel can and must reset to SOURCE_INIT.
            for (int c = 0; c < NUM_CH; c++) begin
                r_src[c*SOURCE_WIDTH +: SOURCE_WIDTH] <= SOURCE_INIT;
            end
            r_upd <= '0;
        end else begin
            r_upd <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_commit && int'(r_pend_ch) == c) begin
                    r_src[c*SOURCE_WIDTH +: SOURCE_WIDTH] <= r_pend_data;
                    r_upd[c]                             <= 1'b1;
                end
            end
        end
    end

    assign tdo           = ena & r_sr[0];
    assign ir_out        = r_ir;
    assign source        = r_src;
    assign source_update = r_upd;

endmodule

// File: tb/tb_altsource_probe_mc.sv
// Directed self-checking bench for altsource_probe_mc (4-channel main DUT plus a 6-channel DUT for range checks).
module tb_altsource_probe_mc;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         ena = 1'b1;
    logic         tck_ena = 1'b0;
    logic         cdr = 1'b0;
    logic         sdr = 1'b0;
    logic         udr = 1'b0;
    logic         tdi = 1'b0;
    logic         source_ena = 1'b0;
    logic [3:0]   ir_in = '0;
    logic [127:0] probe = '0;
    logic         tdo;
    logic [3:0]   ir_out;
    logic [127:0] source;
    logic [3:0]   source_update;

    logic [4:0]   ir_in6 = '0;
    logic [191:0] probe6 = '1;
    logic         tdo6;
    logic [4:0]   ir_out6;
    logic [191:0] source6;
    logic [5:0]   source_update6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    altsource_probe_mc #(
        .NUM_CH(4), .PROBE_WIDTH(32), .SOURCE_WIDTH(32), .SOURCE_INIT(32'h0), .IR_WIDTH(4)
    ) u_dut (
        .source_clk(clk), .clr(clr), .ena(ena), .tck_ena(tck_ena), .ir_in(ir_in),
        .jtag_state_cdr(cdr), .jtag_state_sdr(sdr), .jtag_state_udr(udr),
        .tdi(tdi), .tdo(tdo), .ir_out(ir_out), .probe(probe),
        .source_ena(source_ena), .source(source), .source_update(source_update)
    );

    altsource_probe_mc #(
        .NUM_CH(6), .PROBE_WIDTH(32), .SOURCE_WIDTH(32), .SOURCE_INIT(32'h0), .IR_WIDTH(5)
    ) u_dut6 (
        .source_clk(clk), .clr(clr), .ena(ena), .tck_ena(tck_ena), .ir_in(ir_in6),
        .jtag_state_cdr(cdr), .jtag_state_sdr(sdr), .jtag_state_udr(udr),
        .tdi(tdi), .tdo(tdo6), .ir_out(ir_out6), .probe(probe6),
        .source_ena(source_ena), .source(source6), .source_update(source_update6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tck(input logic c, input logic s, input logic u, input logic d);
        cdr = c; sdr = s; udr = u; tdi = d; tck_ena = 1'b1;
        tick();
        cdr = 1'b0; sdr = 1'b0; udr = 1'b0; tck_ena = 1'b0;
    endtask

    task automatic capture(input logic [3:0] ir);
        ir_in = ir;
        tck(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shift_word(input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < 32; i++) begin
            dout[i] = tdo;
            tck(1'b0, 1'b1, 1'b0, din[i]);
        end
    endtask

    task automatic write_word(input logic [3:0] ir, input logic [31:0] data);
        logic [31:0] unused_out;
        capture(ir);
        shift_word(data, unused_out);
        tck(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
        tick();
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b want=0", tdo); end
        total++; if (ir_out !== 4'h0) begin bad++; $display("FAIL reset_ir_out got=%h want=0", ir_out); end
        total++; if (source !== 128'h0) begin bad++; $display("FAIL reset_source got=%h want=0", source); end
        total++; if (source_update !== 4'h0) begin bad++; $display("FAIL reset_update got=%b want=0000", source_update); end
    endtask

    task automatic test_clr_mid_shift();
        logic [31:0] unused_out;
        source_ena = 1'b1;
        write_word(4'b1010, 32'h0000_CAFE);
        repeat (2) tick();
        total++; if (source[64 +: 32] !== 32'h0000_CAFE) begin bad++; $display("FAIL pre_clr_src2 got=%h want=0000cafe", source[64 +: 32]); end
        source_ena = 1'b0;
        write_word(4'b1110, 32'h0000_1111);
        probe[64 +: 32] = 32'hA5A5_0001;
        capture(4'b1001);
        for (int i = 0; i < 3; i++) tck(1'b0, 1'b1, 1'b0, 1'b1);
        #2 clr = 1'b1;
        #1;
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL clr_tdo got=%b want=0", tdo); end
        total++; if (ir_out !== 4'h0) begin bad++; $display("FAIL clr_ir_out got=%h want=0", ir_out); end
        total++; if (source !== 128'h0) begin bad++; $display("FAIL clr_source got=%h want=0", source); end
        total++; if (source_update !== 4'h0) begin bad++; $display("FAIL clr_update got=%b want=0000", source_update); end
        #1 clr = 1'b0;
        source_ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (source_update !== 4'h0) begin bad++; $display("FAIL clr_dropped_pending_pulse got=%b want=0000", source_update); end
        end
        total++; if (source !== 128'h0) begin bad++; $display("FAIL clr_dropped_pending_src got=%h want=0", source); end
        unused_out = '0;
    endtask

    task automatic test_read_probe();
        logic [31:0] got;
        probe[64 +: 32] = 32'hA5A5_0001;
        capture(4'b1001);
        total++; if (ir_out !== 4'b1001) begin bad++; $display("FAIL rp_ir_out got=%b want=1001", ir_out); end
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL rp_first_bit got=%b want=1", tdo); end
        shift_word(32'h0, got);
        total++; if (got !== 32'hA5A5_0001) begin bad++; $display("FAIL rp_word got=%h want=a5a50001", got); end
    endtask

    task automatic test_write_source();
        source_ena = 1'b1;
        write_word(4'b0110, 32'hDEAD_BEEF);
        total++; if (source[32 +: 32] !== 32'h0) begin bad++; $display("FAIL ws_before_commit got=%h want=0", source[32 +: 32]); end
        tick();
        total++; if (source[32 +: 32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_src1 got=%h want=deadbeef", source[32 +: 32]); end
        total++; if (source_update !== 4'b0010) begin bad++; $display("FAIL ws_pulse got=%b want=0010", source_update); end
        tick();
        total++; if (source_update !== 4'b0000) begin bad++; $display("FAIL ws_pulse_end got=%b want=0000", source_update); end
    endtask

    task automatic test_read_source();
        logic [31:0] got;
        capture(4'b0111);
        shift_word(32'h0, got);
        total++; if (got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rs_word got=%h want=deadbeef", got); end
    endtask

    task automatic test_udr_without_capture();
        source_ena = 1'b1;
        ir_in = 4'b0110;
        tick();
        tck(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (source_update !== 4'h0) begin bad++; $display("FAIL lone_udr_pulse got=%b want=0000", source_update); end
        end
    endtask

    task automatic test_pending_hold();
        source_ena = 1'b0;
        write_word(4'b0010, 32'h0000_1234);
        write_word(4'b0010, 32'h0000_5678);
        repeat (3) tick();
        total++; if (source[0 +: 32] !== 32'h0) begin bad++; $display("FAIL hold_src0 got=%h want=0", source[0 +: 32]); end
        total++; if (source_update !== 4'h0) begin bad++; $display("FAIL hold_pulse got=%b want=0000", source_update); end
        source_ena = 1'b1;
        tick();
        total++; if (source[0 +: 32] !== 32'h0000_5678) begin bad++; $display("FAIL hold_commit got=%h want=00005678", source[0 +: 32]); end
        total++; if (source_update !== 4'b0001) begin bad++; $display("FAIL hold_commit_pulse got=%b want=0001", source_update); end
        tick();
        total++; if (source_update !== 4'b0000) begin bad++; $display("FAIL hold_single_pulse got=%b want=0000", source_update); end
        total++; if (source[32 +: 32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold_src1_kept got=%h want=deadbeef", source[32 +: 32]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] unused_out;
        source_ena = 1'b0;
        write_word(4'b0010, 32'hAAAA_0001);
        capture(4'b0010);
        shift_word(32'h5555_0002, unused_out);
        source_ena = 1'b1;
        tck(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (source[0 +: 32] !== 32'hAAAA_0001) begin bad++; $display("FAIL b2b_first got=%h want=aaaa0001", source[0 +: 32]); end
        total++; if (source_update !== 4'b0001) begin bad++; $display("FAIL b2b_first_pulse got=%b want=0001", source_update); end
        tick();
        total++; if (source[0 +: 32] !== 32'h5555_0002) begin bad++; $display("FAIL b2b_second got=%h want=55550002", source[0 +: 32]); end
        total++; if (source_update !== 4'b0001) begin bad++; $display("FAIL b2b_second_pulse got=%b want=0001", source_update); end
        tick();
        total++; if (source_update !== 4'b0000) begin bad++; $display("FAIL b2b_end got=%b want=0000", source_update); end
    endtask

    task automatic test_out_of_range();
        logic [3:0] pat;
        pat = 4'b1101;
        probe[96 +: 32] = 32'h0000_0006;
        probe6 = '1;
        ir_in6 = 5'b11001;
        capture(4'b1101);
        total++; if (ir_out6 !== 5'b11001) begin bad++; $display("FAIL oor_ir_out6 got=%b want=11001", ir_out6); end
        total++; if (tdo6 !== 1'b0) begin bad++; $display("FAIL oor_capture_zero got=%b want=0", tdo6); end
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL ch3_bit0 got=%b want=0", tdo); end
        for (int i = 0; i < 4; i++) begin
            tck(1'b0, 1'b1, 1'b0, pat[i]);
            total++; if (tdo6 !== pat[i]) begin bad++; $display("FAIL oor_bypass_echo step=%0d got=%b want=%b", i, tdo6, pat[i]); end
            if (i == 0) begin
                total++; if (tdo !== 1'b1) begin bad++; $display("FAIL ch3_bit1 got=%b want=1", tdo); end
            end
        end
    endtask

    task automatic test_ena_low();
        probe[64 +: 32] = 32'hA5A5_0001;
        capture(4'b1001);
        ena = 1'b0;
        #1;
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL ena_low_tdo got=%b want=0", tdo); end
        tck(1'b0, 1'b1, 1'b0, 1'b0);
        ena = 1'b1;
        #1;
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL ena_low_no_shift got=%b want=1", tdo); end
    endtask

    task automatic test_probe_latency();
        probe[32 +: 32] = 32'h0;
        repeat (3) tick();
`ifdef PROBE_SYNC_EN
        probe[32 +: 32] = 32'h1;
        tick();
        capture(4'b0101);
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL sync_one_cycle got=%b want=0", tdo); end
        capture(4'b0101);
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL sync_two_cycle got=%b want=1", tdo); end
`else
        capture(4'b0101);
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL direct_old got=%b want=0", tdo); end
        probe[32 +: 32] = 32'h1;
        capture(4'b0101);
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL direct_new got=%b want=1", tdo); end
`endif
    endtask

    initial begin
        test_reset();
        test_clr_mid_shift();
        test_read_probe();
        test_write_source();
        test_read_source();
        test_udr_without_capture();
        test_pending_hold();
        test_back_to_back();
        test_out_of_range();
        test_ena_low();
        test_probe_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
